// File: rtl/cp_pkg.sv
// Shared definitions for the cyclic-prefix inserter: read-FSM states, default sizes, clog2 helper.
package cp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } rd_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_N      = 16;
  localparam int DEF_CP_LEN = 4;

  function automatic int cp_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cp_bank_ram.sv
// Two-bank x N-entry sample store: one synchronous write port, one asynchronous read port, no data reset.
module cp_bank_ram #(
  parameter int WORD_W = 32,
  parameter int N      = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [IDX_W-1:0]  widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rbank,
  input  logic [IDX_W-1:0]  ridx,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, widx}] <= wdata;
  end

  assign rdata = mem[{rbank, ridx}];

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: ping-pong buffers IFFT symbols and replays the last CP_LEN samples before the body.
// Optional status outputs (sym_cnt, frame_err) are enabled by defining CPI_STATUS_EN.
module cp_inserter
  import cp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  parameter int CP_LEN = DEF_CP_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     out_sof,
  output logic                     out_eof,
  input  logic                     out_ready
`ifdef CPI_STATUS_EN
  ,
  output logic [15:0]              sym_cnt,
  output logic                     frame_err
`endif
);

  localparam int IDX_W = cp_clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] CP_START = IDX_W'(N - CP_LEN);

  logic [1:0]          full;
  logic                wr_bank;
  logic [IDX_W-1:0]    wr_idx;
  logic                rd_bank;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    rd_idx_next;
  rd_state_t           state;
  rd_state_t           state_next;
  logic                rd_done;
  logic                wr_en;
  logic                frame_evt;
  logic [2*DATA_W-1:0] rd_data;

  assign in_ready  = ~full[wr_bank];
  assign wr_en     = in_valid & in_ready;
  // in_last only matters when it cuts a symbol short; on the final sample it is redundant.
  assign frame_evt = wr_en & in_last & (wr_idx != LAST_IDX);

  cp_bank_ram #(
    .WORD_W (2*DATA_W),
    .N      (N),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .wbank (wr_bank),
    .widx  (wr_idx),
    .wdata ({in_real, in_imag}),
    .rbank (rd_bank),
    .ridx  (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (wr_en) begin
        if (wr_idx == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else if (in_last) begin
          wr_idx <= '0;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      // Writer only targets a free bank and reader only frees a full one, so these never hit the same bit.
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state  <= state_next;
      rd_idx <= rd_idx_next;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  always_comb begin
    state_next  = state;
    rd_idx_next = rd_idx;
    rd_done     = 1'b0;
    out_valid   = 1'b0;
    out_sof     = 1'b0;
    out_eof     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full[rd_bank]) begin
          state_next  = ST_CP;
          rd_idx_next = CP_START;
        end
      end
      ST_CP: begin
        out_valid = 1'b1;
        out_sof   = (rd_idx == CP_START);
        if (out_ready) begin
          if (rd_idx == LAST_IDX) begin
            state_next  = ST_BODY;
            rd_idx_next = '0;
          end else begin
            rd_idx_next = rd_idx + IDX_W'(1);
          end
        end
      end
      ST_BODY: begin
        out_valid = 1'b1;
        out_eof   = (rd_idx == LAST_IDX);
        if (out_ready) begin
          if (rd_idx == LAST_IDX) begin
            rd_done     = 1'b1;
            state_next  = ST_IDLE;
            rd_idx_next = '0;
          end else begin
            rd_idx_next = rd_idx + IDX_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Data is forced to zero whenever no sample is being offered.
  assign out_real = out_valid ? rd_data[2*DATA_W-1:DATA_W] : '0;
  assign out_imag = out_valid ? rd_data[DATA_W-1:0]        : '0;

`ifdef CPI_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt   <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      if (rd_done)   sym_cnt   <= sym_cnt + 16'd1;
      if (frame_evt) frame_err <= 1'b1;
    end
  end
`else
  logic unused_frame_evt;
  assign unused_frame_evt = frame_evt;
`endif

endmodule

// File: tb/tb_cp_inserter.sv
// Self-checking bench for cp_inserter: queue-based symbol model, directed cases plus randomized traffic.
module tb_cp_inserter;

  localparam int DATA_W = 16;
  localparam int N      = 16;
  localparam int CP_LEN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                     in_valid, in_last, in_ready;
  logic signed [DATA_W-1:0] in_real, in_imag;
  logic                     out_valid, out_sof, out_eof, out_ready;
  logic signed [DATA_W-1:0] out_real, out_imag;

  logic                     b_in_valid, b_in_last, b_in_ready;
  logic signed [DATA_W-1:0] b_in_real, b_in_imag;
  logic                     b_out_valid, b_out_sof, b_out_eof, b_out_ready;
  logic signed [DATA_W-1:0] b_out_real, b_out_imag;

`ifdef CPI_STATUS_EN
  logic [15:0] sym_cnt, b_sym_cnt;
  logic        frame_err, b_frame_err;
`endif

  cp_inserter #(.DATA_W(DATA_W), .N(N), .CP_LEN(CP_LEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag),
    .out_sof(out_sof), .out_eof(out_eof), .out_ready(out_ready)
`ifdef CPI_STATUS_EN
    , .sym_cnt(sym_cnt), .frame_err(frame_err)
`endif
  );

  cp_inserter #(.DATA_W(DATA_W), .N(N), .CP_LEN(1)) dut_cp1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_real(b_in_real), .in_imag(b_in_imag), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_real(b_out_real), .out_imag(b_out_imag),
    .out_sof(b_out_sof), .out_eof(b_out_eof), .out_ready(b_out_ready)
`ifdef CPI_STATUS_EN
    , .sym_cnt(b_sym_cnt), .frame_err(b_frame_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: each complete symbol expands to its prefix plus body in one queue.
  typedef struct {
    int re;
    int im;
    bit sof;
    bit eof;
  } samp_t;

  samp_t exp_q[$];
  int    part_re[$];
  int    part_im[$];
  int    pending;
  bit    exp_ferr;
  int    exp_sym;
  int    cyc;
  bit    saw_block;
  int    log_re[$];
  bit    log_sof[$];
  bit    log_eof[$];
  int    log_cyc[$];
  bit    prev_stall;
  int    prev_re, prev_im;
  bit    prev_sof, prev_eof;
  int    b_re[$];
  bit    b_sof[$];
  bit    b_eof[$];
  int    ready_mode;

  function automatic void push_symbol();
    samp_t s;
    for (int i = N - CP_LEN; i < N; i++) begin
      s.re = part_re[i]; s.im = part_im[i]; s.sof = (i == N - CP_LEN); s.eof = 1'b0;
      exp_q.push_back(s);
    end
    for (int i = 0; i < N; i++) begin
      s.re = part_re[i]; s.im = part_im[i]; s.sof = 1'b0; s.eof = (i == N - 1);
      exp_q.push_back(s);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete(); part_re.delete(); part_im.delete();
      pending = 0; exp_ferr = 1'b0; exp_sym = 0; prev_stall = 1'b0;
    end else begin
`ifdef CPI_STATUS_EN
      chk("sym_cnt", sym_cnt, exp_sym & 16'hFFFF);
      chk("frame_err", frame_err, exp_ferr);
`endif
      chk("in_ready", in_ready, pending < 2);
      if (!in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_real", out_real, prev_re);
        chk("hold_imag", out_imag, prev_im);
        chk("hold_sof", out_sof, prev_sof);
        chk("hold_eof", out_eof, prev_eof);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("out_real", out_real, exp_q[0].re);
          chk("out_imag", out_imag, exp_q[0].im);
          chk("out_sof", out_sof, exp_q[0].sof);
          chk("out_eof", out_eof, exp_q[0].eof);
          if (out_ready) begin
            log_re.push_back(out_real); log_sof.push_back(out_sof);
            log_eof.push_back(out_eof); log_cyc.push_back(cyc);
            if (exp_q[0].eof) begin
              pending--;
              exp_sym++;
            end
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_data", {out_real, out_imag, out_sof, out_eof}, 0);
      end
      if (in_valid && in_ready) begin
        part_re.push_back(in_real);
        part_im.push_back(in_imag);
        if (part_re.size() == N) begin
          push_symbol();
          pending++;
          part_re.delete(); part_im.delete();
        end else if (in_last) begin
          part_re.delete(); part_im.delete();
          exp_ferr = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_re = out_real; prev_im = out_imag; prev_sof = out_sof; prev_eof = out_eof;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      b_re.push_back(b_out_real); b_sof.push_back(b_out_sof); b_eof.push_back(b_out_eof);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // last_at < 0 marks in_last on every N-th sample; otherwise only at sample index last_at.
  task automatic send(input int n, input int last_at, input int base, input int gap_pct);
    int t;
    for (int k = 0; k < n; k++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_real  = DATA_W'(base + k);
      in_imag  = DATA_W'(-(base + k));
      in_last  = (last_at >= 0) ? (k == last_at) : ((k % N) == N - 1);
      t = 0;
      while (!in_ready && t < 300) begin
        @(posedge clk); #1; t++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_done", t < 3000, 1);
  endtask

  int t1_tab[20] = '{12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  task automatic check_t1(input string tag);
    chk({tag, "_count"}, log_re.size(), 20);
    if (log_re.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        chk({tag, "_real"}, log_re[i], t1_tab[i]);
        chk({tag, "_sof"}, log_sof[i], i == 0);
        chk({tag, "_eof"}, log_eof[i], i == 19);
      end
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; ready_mode = 0;
    in_valid = 1'b0; in_last = 1'b0; in_real = '0; in_imag = '0;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_real = '0; b_in_imag = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", {out_real, out_imag, out_sof, out_eof}, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    rst = 1'b0;

    // Single symbol, with output latency pinned
    log_re.delete(); log_sof.delete(); log_eof.delete(); log_cyc.delete();
    send(N, -1, 0, 0);
    chk("t1_lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat_edge2", out_valid, 1);
    chk("t1_first_sof", out_sof, 1);
    drain();
    check_t1("t1");

    // Three symbols back to back
    log_re.delete(); log_sof.delete(); log_eof.delete(); log_cyc.delete();
    saw_block = 1'b0;
    send(3 * N, -1, 0, 0);
    drain();
    chk("t2_count", log_re.size(), 60);
    chk("t2_blocked", saw_block, 1);
    if (log_re.size() == 60) begin
      chk("t2_sym1_prefix", log_re[20], 28);
      chk("t2_sym2_last", log_re[59], 47);
      chk("t2_period1", log_cyc[20] - log_cyc[0], N + CP_LEN + 1);
      chk("t2_period2", log_cyc[40] - log_cyc[20], N + CP_LEN + 1);
    end

    // Toggling out_ready
    log_re.delete(); log_sof.delete(); log_eof.delete(); log_cyc.delete();
    ready_mode = 1;
    send(N, -1, 0, 0);
    drain();
    ready_mode = 0;
    check_t1("t3");

    // Framing error then a good symbol
    log_re.delete(); log_sof.delete(); log_eof.delete(); log_cyc.delete();
    send(10, 9, 0, 0);
    send(N, -1, 100, 0);
    drain();
    chk("t4_count", log_re.size(), 20);
    if (log_re.size() == 20) begin
      chk("t4_prefix0", log_re[0], 112);
      chk("t4_body0", log_re[4], 100);
    end
`ifdef CPI_STATUS_EN
    chk("t4_frame_err", frame_err, 1);
`endif

    // Reset mid-BODY
    log_re.delete(); log_sof.delete(); log_eof.delete(); log_cyc.delete();
    send(N, -1, 0, 0);
    t = 0;
    while (log_re.size() < 10 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("t5_reach_body", log_re.size() >= 10, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    rst = 1'b0;
`ifdef CPI_STATUS_EN
    chk("t5_sym_cnt0", sym_cnt, 0);
    chk("t5_frame_err0", frame_err, 0);
`endif
    log_re.delete(); log_sof.delete(); log_eof.delete(); log_cyc.delete();
    send(N, -1, 50, 0);
    drain();
    chk("t5_count", log_re.size(), 20);
    if (log_re.size() == 20) chk("t5_prefix0", log_re[0], 62);
`ifdef CPI_STATUS_EN
    chk("t5_sym_cnt1", sym_cnt, 1);
`endif

    // Randomized traffic with stalls, gaps and occasional short symbols
    ready_mode = 2;
    for (int s = 0; s < 14; s++) begin
      if ($urandom_range(0, 4) == 0) begin
        int n;
        n = $urandom_range(1, N - 1);
        send(n, n - 1, $urandom_range(0, 30000), 20);
      end else begin
        send(N, -1, $urandom_range(0, 30000) - 15000, 30);
      end
    end
    drain();
    ready_mode = 0;

    // CP_LEN = 1 instance
    for (int k = 0; k < N; k++) begin
      b_in_valid = 1'b1;
      b_in_real  = DATA_W'(k);
      b_in_imag  = DATA_W'(-k);
      b_in_last  = (k == N - 1);
      t = 0;
      while (!b_in_ready && t < 100) begin
        @(posedge clk); #1; t++;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    t = 0;
    while (b_re.size() < N + 1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("t6_count", b_re.size(), N + 1);
    if (b_re.size() == N + 1) begin
      chk("t6_prefix", b_re[0], 15);
      for (int i = 1; i <= N; i++) chk("t6_body", b_re[i], i - 1);
      chk("t6_sof_first", b_sof[0], 1);
      chk("t6_sof_second", b_sof[1], 0);
      chk("t6_eof_last", b_eof[N], 1);
      chk("t6_eof_early", b_eof[N - 1], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
